// File: rtl/gcd_request_arbiter.sv
// Round-robin arbiter sharing one GCD engine among N requesters.
// Latches the winner's operands, starts the engine, returns the result.
module gcd_request_arbiter #(
  parameter int N       = 2,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   resp_valid,
  output logic [W-1:0]   resp_gcd,
  output logic           resp_err,
  output logic           busy,
  output logic           gcd_start,
  output logic [W-1:0]   gcd_a,
  output logic [W-1:0]   gcd_b,
  input  logic           gcd_done,
  input  logic [W-1:0]   gcd_result
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ZERO,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] owner;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic          found;
  logic [N-1:0]  rot;
  logic [W-1:0]  a_sel;
  logic [W-1:0]  b_sel;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  result;
  logic          err;
  logic [TW-1:0] timer;
  logic          expire;
  logic [N-1:0]  own_oh;

  // rot[0] is the requester right after last, so the scan is fair
  always_comb begin
    rot   = N'({req, req} >> (int'(last) + 1));
    found = 1'b0;
    pick  = last;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pick  = IW'((int'(last) + 1 + k) % N);
      end
    end
  end

  assign a_sel  = a_in[int'(pick)*W +: W];
  assign b_sel  = b_in[int'(pick)*W +: W];
  assign expire = (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (found) begin
          if (a_sel == '0 || b_sel == '0) state_nx = ZERO;
          else                            state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      ZERO:  state_nx = RESP;
      WAIT: begin
        if (gcd_done || expire) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      last   <= IW'(N - 1);
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      err    <= 1'b0;
      timer  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (found) begin
            owner <= pick;
            last  <= pick;
            a_q   <= a_sel;
            b_q   <= b_sel;
          end
        end
        ISSUE: timer <= '0;
        ZERO: begin
          result <= a_q | b_q;
          err    <= 1'b0;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (gcd_done) begin
            result <= gcd_result;
            err    <= 1'b0;
          end else if (expire) begin
            result <= '0;
            err    <= 1'b1;
          end
        end
        RESP:    err <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    own_oh        = '0;
    own_oh[owner] = 1'b1;
  end

  always_comb begin
    ack        = '0;
    resp_valid = '0;
    resp_gcd   = '0;
    resp_err   = 1'b0;
    gcd_start  = 1'b0;
    unique case (1'b1)
      (state == ISSUE): begin
        ack       = own_oh;
        gcd_start = 1'b1;
      end
      (state == ZERO): ack = own_oh;
      (state == RESP): begin
        resp_valid = own_oh;
        resp_gcd   = result;
        resp_err   = err;
      end
      default: ;
    endcase
  end

  assign busy  = (state != IDLE);
  assign gcd_a = a_q;
  assign gcd_b = b_q;

endmodule

// File: tb/tb_gcd_request_arbiter.sv
// Bench for gcd_request_arbiter: timing-rule model checked every cycle
// plus directed scenarios with literal expectations.
module tb_gcd_request_arbiter;

  localparam int N  = 2;
  localparam int W  = 16;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]   ack;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_gcd;
  logic           resp_err;
  logic           busy;
  logic           gcd_start;
  logic [W-1:0]   gcd_a;
  logic [W-1:0]   gcd_b;
  logic           gcd_done;
  logic [W-1:0]   gcd_result;

  int errors = 0;
  int checks = 0;

  gcd_request_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a_in(a_in), .b_in(b_in), .ack(ack),
    .resp_valid(resp_valid), .resp_gcd(resp_gcd),
    .resp_err(resp_err), .busy(busy),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_done(gcd_done), .gcd_result(gcd_result)
  );

  always #5 clk = ~clk;

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural engine: done pulse 5 cycles after start
  logic         eng_en = 1'b1;
  logic         stray = 1'b0;
  logic         eng_done;
  logic [W-1:0] eres;
  int           ecnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt     <= 0;
      eng_done <= 1'b0;
      eres     <= '0;
    end else begin
      eng_done <= 1'b0;
      if (gcd_start && eng_en) begin
        ecnt <= 4;
        eres <= W'(gcd_ref(int'(gcd_a), int'(gcd_b)));
      end else if (ecnt > 0) begin
        ecnt <= ecnt - 1;
        if (ecnt == 1) eng_done <= 1'b1;
      end
    end
  end

  assign gcd_done   = eng_done | stray;
  assign gcd_result = eres;

  // Transaction model: expected outputs from grant/response times
  int           cyc = 0;
  bit           m_act = 0;
  bit           m_zero = 0;
  bit           m_err = 0;
  int           m_own = 0;
  int           m_last = N - 1;
  int           m_t0 = 0;
  int           m_rt = -1;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_ga = '0;
  logic [W-1:0] m_gb = '0;
  int           ack_log[$];
  int           n_start = 0;

  always @(negedge clk) begin
    logic [N-1:0] e_ack;
    logic [N-1:0] e_rv;
    logic [W-1:0] e_gcd;
    logic         e_err;
    logic         e_busy;
    logic         e_start;
    logic [54:0]  exp_v;
    logic [54:0]  got_v;
    int           idx;
    cyc++;
    if (!rst_n) begin
      m_act  = 0;
      m_last = N - 1;
      m_ga   = '0;
      m_gb   = '0;
    end
    e_ack   = '0;
    e_rv    = '0;
    e_gcd   = '0;
    e_err   = 1'b0;
    e_busy  = 1'b0;
    e_start = 1'b0;
    if (m_act) begin
      if (cyc == m_t0) begin
        e_ack[m_own] = 1'b1;
        e_start      = !m_zero;
      end
      e_busy = (cyc >= m_t0);
      if (cyc == m_rt) begin
        e_rv[m_own] = 1'b1;
        e_gcd       = m_res;
        e_err       = m_err;
      end
    end
    exp_v = {e_ack, e_rv, e_gcd, e_err, e_busy, e_start, m_ga, m_gb};
    got_v = {ack, resp_valid, resp_gcd, resp_err, busy, gcd_start,
             gcd_a, gcd_b};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL model cyc=%0d: got %h expected %h", cyc, got_v, exp_v);
    end
    if (rst_n) begin
      if (|ack) ack_log.push_back(ack[1] ? 1 : 0);
      if (gcd_start) n_start++;
      if (m_act) begin
        if (cyc == m_rt) begin
          m_act = 0;
        end else if (!m_zero && m_rt < 0 && cyc > m_t0) begin
          if (gcd_done) begin
            m_rt  = cyc + 1;
            m_res = gcd_result;
            m_err = 0;
          end else if (cyc == m_t0 + TO) begin
            m_rt  = cyc + 1;
            m_res = '0;
            m_err = 1;
          end
        end
      end else if (|req) begin
        idx = -1;
        for (int k = 1; k <= N; k++) begin
          if (idx < 0 && req[(m_last + k) % N]) idx = (m_last + k) % N;
        end
        m_own  = idx;
        m_last = idx;
        m_ga   = a_in[idx*W +: W];
        m_gb   = b_in[idx*W +: W];
        m_zero = (m_ga == '0) || (m_gb == '0);
        m_t0   = cyc + 1;
        m_rt   = m_zero ? cyc + 2 : -1;
        m_res  = m_ga | m_gb;
        m_err  = 0;
        m_act  = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
  endtask

  task automatic wait_ack(input int i, input string nm);
    int n = 0;
    while (!ack[i] && n < 100) begin
      tick();
      n++;
    end
    chk({nm, "_ack"}, 64'(ack), 64'(1 << i));
    req[i] = 1'b0;
  endtask

  task automatic wait_resp(input int i, input int g, input bit e,
                           input string nm);
    int n = 0;
    while (!resp_valid[i] && n < 100) begin
      tick();
      n++;
    end
    chk({nm, "_rv"}, 64'(resp_valid), 64'(1 << i));
    chk({nm, "_gcd"}, 64'(resp_gcd), 64'(g));
    chk({nm, "_err"}, 64'(resp_err), 64'(e));
  endtask

  task automatic serve(input int i, input int a, input int b,
                       input int g, input bit st, input string nm);
    set_op(i, a, b);
    req[i] = 1'b1;
    wait_ack(i, nm);
    chk({nm, "_ga"}, 64'(gcd_a), 64'(a));
    chk({nm, "_gb"}, 64'(gcd_b), 64'(b));
    chk({nm, "_start"}, 64'(gcd_start), 64'(st));
    wait_resp(i, g, 1'b0, nm);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    stray = 1'b0;
    tick();
    tick();
    chk("reset_outs", {ack, resp_valid, resp_gcd, resp_err, busy,
                       gcd_start, gcd_a, gcd_b}, 64'd0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    do_reset();

    // single request, then the ack pulse must end
    set_op(0, 18, 12);
    req[0] = 1'b1;
    wait_ack(0, "t1");
    chk("t1_ga", 64'(gcd_a), 64'd18);
    chk("t1_gb", 64'(gcd_b), 64'd12);
    chk("t1_start", 64'(gcd_start), 64'd1);
    tick();
    chk("t1_ack_once", 64'({ack, gcd_start}), 64'd0);
    wait_resp(0, 6, 1'b0, "t1");
    tick();

    // simultaneous requests after reset: 0 first
    do_reset();
    set_op(0, 1000, 160);
    set_op(1, 3, 15);
    req = 2'b11;
    wait_ack(0, "t2a");
    wait_resp(0, 40, 1'b0, "t2a");
    wait_ack(1, "t2b");
    wait_resp(1, 3, 1'b0, "t2b");
    tick();

    // continuous requests alternate
    do_reset();
    set_op(0, 48, 36);
    set_op(1, 35, 49);
    ack_log.delete();
    req = 2'b11;
    n = 0;
    while (ack_log.size() < 6 && n < 400) begin
      tick();
      n++;
    end
    req = '0;
    chk("t3_count", 64'(ack_log.size()), 64'd6);
    foreach (ack_log[j]) chk("t3_order", 64'(ack_log[j]), 64'(j % 2));
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end

    // zero operands bypass the engine
    n_start = 0;
    serve(1, 0, 15, 15, 1'b0, "t4a");
    serve(1, 0, 0, 0, 1'b0, "t4b");
    chk("t4_nostart", 64'(n_start), 64'd0);

    // engine silent: timeout abort, late done ignored
    eng_en = 1'b0;
    set_op(0, 7, 21);
    req[0] = 1'b1;
    wait_ack(0, "t5");
    n = 0;
    while (!resp_valid[0] && n < 50) begin
      tick();
      n++;
    end
    chk("t5_latency", 64'(n), 64'd9);
    chk("t5_gcd", 64'(resp_gcd), 64'd0);
    chk("t5_err", 64'(resp_err), 64'd1);
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (3) begin
      tick();
      chk("t5_late_done", 64'({resp_valid, busy}), 64'd0);
    end
    eng_en = 1'b1;

    // reset during WAIT aborts silently
    set_op(0, 100, 75);
    req[0] = 1'b1;
    wait_ack(0, "t6");
    tick();
    tick();
    chk("t6_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {ack, resp_valid, resp_gcd, resp_err, busy,
                        gcd_start, gcd_a, gcd_b}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (3) begin
      tick();
      chk("t6_stray", 64'({resp_valid, busy}), 64'd0);
    end
    set_op(0, 100, 75);
    set_op(1, 35, 49);
    req = 2'b11;
    wait_ack(0, "t6a");
    wait_resp(0, 25, 1'b0, "t6a");
    wait_ack(1, "t6b");
    wait_resp(1, 7, 1'b0, "t6b");
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
